// File: rtl/noise_pkg.sv
// noise_pkg: shared widths, types and rounding helper for the Box-Muller output stage
package noise_pkg;
    localparam int F_W         = 17;
    localparam int G_W         = 16;
    localparam int OUT_W       = 16;
    localparam int PROD_W      = 33;
    localparam int ROUND_SHIFT = 17;
    localparam logic signed [OUT_W-1:0] SAT_MAX = 16'sd32767;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;
    typedef enum logic {PH_X0, PH_X1} phase_e;

    typedef struct packed {
        logic signed [OUT_W-1:0] x0;
        logic signed [OUT_W-1:0] x1;
    } pair_t;

    // Round half away from zero on the magnitude, clamp to the symmetric range, then negate.
    function automatic logic [OUT_W-1:0] round_sat(input logic [PROD_W-1:0] p, input logic neg);
        logic [PROD_W:0] r;
        logic [PROD_W-ROUND_SHIFT:0] m;
        logic [OUT_W-1:0] s;
        r = {1'b0, p} + ((PROD_W+1)'(1) << (ROUND_SHIFT-1));
        m = r[PROD_W:ROUND_SHIFT];
        s = (m > (PROD_W-ROUND_SHIFT+1)'(32767)) ? SAT_MAX : m[OUT_W-1:0];
        return neg ? -s : s;
    endfunction
endpackage

// File: rtl/pair_fifo.sv
// pair_fifo: power-of-two synchronous FIFO with occupancy count
module pair_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + AW'(1);
            if (pop_i) rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/bm_output_stage.sv
// bm_output_stage: scales sqrt magnitude by cos/sin, rounds/saturates/signs, and serializes x0,x1 pairs
module bm_output_stage import noise_pkg::*; #(
    parameter int PAIR_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [F_W-1:0]   f,
    input  logic [G_W-1:0]   g0,
    input  logic [G_W-1:0]   g1,
    input  logic [1:0]       quad,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_idx
);
    localparam int CW = $clog2(PAIR_DEPTH) + 1;

    logic              s1_valid_q, s2_valid_q;
    logic [F_W-1:0]    f_q;
    logic [G_W-1:0]    g0_q, g1_q;
    logic [1:0]        quad_q, quad2_q;
    logic [PROD_W-1:0] p0_q, p1_q;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    pair_t             push_pair, head;
    phase_e            phase_q, phase_d;
    logic              accept, fire, pop;

    // Counting in-flight pairs guarantees the FIFO never sees a push while full.
    assign occ      = (CW+1)'(count) + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
    assign in_ready = occ < (CW+1)'(PAIR_DEPTH);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            f_q        <= '0;
            g0_q       <= '0;
            g1_q       <= '0;
            quad_q     <= '0;
            quad2_q    <= '0;
            p0_q       <= '0;
            p1_q       <= '0;
            phase_q    <= PH_X0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                f_q    <= f;
                g0_q   <= g0;
                g1_q   <= g1;
                quad_q <= quad;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                p0_q    <= PROD_W'(f_q) * PROD_W'(g0_q);
                p1_q    <= PROD_W'(f_q) * PROD_W'(g1_q);
                quad2_q <= quad_q;
            end
            phase_q <= phase_d;
        end
    end

    assign push_pair.x0 = round_sat(p0_q, quad2_q[1] ^ quad2_q[0]);
    assign push_pair.x1 = round_sat(p1_q, quad2_q[1]);

    pair_fifo #(.DEPTH(PAIR_DEPTH), .W(2*OUT_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s2_valid_q),
        .din_i   (push_pair),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (count)
    );

    assign out_valid = count != '0;
    assign fire      = out_valid && out_ready;
    assign pop       = fire && phase_q == PH_X1;

    always_comb begin
        phase_d = phase_q;
        if (fire) phase_d = (phase_q == PH_X0) ? PH_X1 : PH_X0;
    end

    assign out_data = out_valid ? ((phase_q == PH_X1) ? head.x1 : head.x0) : '0;
    assign out_idx  = phase_q == PH_X1;
endmodule

// File: tb/tb_bm_output_stage.sv
// tb_bm_output_stage: table vectors, corner sequences and random traffic against a scoreboard model
module tb_bm_output_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_idx;
    logic [16:0] f;
    logic [15:0] g0, g1, out_data;
    logic [1:0]  quad;

    int n_cmp = 0;
    int n_fail = 0;
    int acc = 0;
    logic [16:0] expq[$];

    typedef struct {
        logic [16:0] f;
        logic [15:0] g0, g1;
        logic [1:0]  q;
        logic [15:0] e0, e1;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    bm_output_stage #(.PAIR_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .f(f), .g0(g0), .g1(g1), .quad(quad),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Gaussian sample from plain integer arithmetic: |f*g| in output LSBs, rounded, clamped, signed.
    function automatic logic [15:0] model(input int unsigned fv, input int unsigned gv, input bit neg);
        longint m;
        m = (longint'(fv) * longint'(gv) + 65536) / 131072;
        if (m > 32767) m = 32767;
        if (neg) m = -m;
        return 16'(m);
    endfunction

    task automatic step(input logic iv, input logic [16:0] fv, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] q, input logic ordy, input logic [15:0] e0, input logic [15:0] e1);
        logic [16:0] e;
        in_valid = iv; f = fv; g0 = a; g1 = b; quad = q; out_ready = ordy;
        @(negedge clk);
        if (in_valid && in_ready) begin
            expq.push_back({1'b0, e0});
            expq.push_back({1'b1, e1});
            acc++;
        end
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_sample", 32'(out_data), 32'hDEAD);
            end else begin
                e = expq.pop_front();
                chk("sample_data", 32'(out_data), 32'(e[15:0]));
                chk("sample_idx", 32'(out_idx), 32'(e[16]));
            end
        end
        n_cmp++;
        if (expq.size() > 8) begin
            n_fail++;
            $display("FAIL occupancy: %0d samples outstanding, limit 8", expq.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_rand(input logic iv, input logic ordy);
        logic [16:0] fv;
        logic [15:0] a, b;
        logic [1:0]  q;
        fv = 17'($urandom);
        a  = 16'($urandom);
        b  = 16'($urandom);
        q  = 2'($urandom);
        step(iv, fv, a, b, q, ordy, model(fv, a, q == 2'd1 || q == 2'd2), model(fv, b, q >= 2'd2));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && expq.size() > 0; i++) step(1'b0, '0, '0, '0, '0, 1'b1, '0, '0);
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        int a0;
        tbl[0] = '{17'h02000, 16'h4000, 16'h8000, 2'd0, 16'h0400, 16'h0800};
        tbl[1] = '{17'h02000, 16'h4000, 16'h8000, 2'd2, 16'hFC00, 16'hF800};
        tbl[2] = '{17'h02000, 16'h4000, 16'h8000, 2'd1, 16'hFC00, 16'h0800};
        tbl[3] = '{17'h02000, 16'h4000, 16'h8000, 2'd3, 16'h0400, 16'hF800};
        tbl[4] = '{17'h00001, 16'h8000, 16'h8000, 2'd1, 16'h0000, 16'h0000};
        tbl[5] = '{17'h00002, 16'h8000, 16'h8000, 2'd1, 16'hFFFF, 16'h0001};
        tbl[6] = '{17'h00003, 16'h8000, 16'h8000, 2'd1, 16'hFFFF, 16'h0001};
        tbl[7] = '{17'h1FFFF, 16'hFFFF, 16'hFFFF, 2'd1, 16'h8001, 16'h7FFF};
        tbl[8] = '{17'h00000, 16'hFFFF, 16'h1234, 2'd2, 16'h0000, 16'h0000};

        rst_n = 1'b0; in_valid = 0; out_ready = 0; f = 0; g0 = 0; g1 = 0; quad = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // latency: accepted at edge T, x0 visible only after T+2
        step(1'b1, 17'h02000, 16'h4000, 16'h8000, 2'd0, 1'b0, 16'h0400, 16'h0800);
        chk("lat_T", 32'(out_valid), 0);
        step(1'b0, '0, '0, '0, '0, 1'b0, '0, '0);
        chk("lat_T1", 32'(out_valid), 0);
        step(1'b0, '0, '0, '0, '0, 1'b0, '0, '0);
        chk("lat_T2_valid", 32'(out_valid), 1);
        chk("lat_T2_data", 32'(out_data), 32'h0400);
        chk("lat_T2_idx", 32'(out_idx), 0);
        step(1'b0, '0, '0, '0, '0, 1'b0, '0, '0);
        chk("stall_data", 32'(out_data), 32'h0400);
        drain();

        for (int i = 0; i < 9; i++) begin
            step(1'b1, tbl[i].f, tbl[i].g0, tbl[i].g1, tbl[i].q, 1'b1, tbl[i].e0, tbl[i].e1);
            drain();
        end

        // backpressure: exactly PAIR_DEPTH pairs admitted
        a0 = acc;
        for (int i = 0; i < 10; i++) step_rand(1'b1, 1'b0);
        chk("bp_accepted", 32'(acc - a0), 4);
        chk("bp_in_ready", 32'(in_ready), 0);
        drain();
        chk("bp_ready_back", 32'(in_ready), 1);

        // reset with three pairs buffered while in the x1 phase
        for (int i = 0; i < 3; i++) step_rand(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step_rand(1'b0, 1'b0);
        step_rand(1'b0, 1'b1);
        in_valid = 0; out_ready = 0;
        chk("pre_rst_idx", 32'(out_idx), 1);
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        expq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 17'h02000, 16'h4000, 16'h8000, 2'd3, 1'b1, 16'h0400, 16'hF800);
        drain();

        for (int i = 0; i < 400; i++) step_rand($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        for (int i = 0; i < 100; i++) step_rand(1'b1, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
